// File: rtl/cache_refill_controller_if.sv
//==============================================================================
// Module      : cache_refill_controller_if
// Description : Bundle of the CPU data port, cache port, memory port and
//               performance counters seen by the cache refill controller.
//               The master modport is the controller; slave is its environment.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface cache_refill_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  // CPU side
  logic                  req_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  stall_o;
  // Cache side
  logic [ADDR_WIDTH-1:0] cache_addr_o;
  logic [DATA_WIDTH-1:0] cache_wdata_o;
  logic                  cache_fill_o;
  logic [DATA_WIDTH-1:0] cache_rdata_i;
  logic                  cache_hit_i;
  // Memory side
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;
  // Performance counters
  logic [CNT_WIDTH-1:0]  hit_count_o;
  logic [CNT_WIDTH-1:0]  miss_count_o;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, cache_rdata_i, cache_hit_i,
           mem_rdata_i, mem_ack_i,
    output rdata_o, stall_o, cache_addr_o, cache_wdata_o, cache_fill_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           hit_count_o, miss_count_o
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, cache_rdata_i, cache_hit_i,
           mem_rdata_i, mem_ack_i,
    input  rdata_o, stall_o, cache_addr_o, cache_wdata_o, cache_fill_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           hit_count_o, miss_count_o
  );
endinterface

`default_nettype wire

// File: rtl/cache_refill_controller.sv
//==============================================================================
// Module      : cache_refill_controller
// Description : Sequences CPU loads/stores between a two-way set-associative
//               data cache and main memory. Load hits complete with no stall;
//               load misses fetch the word and refill the cache; stores are
//               write-through, no-write-allocate. Saturating hit/miss counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cache_refill_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  wire                          clk,
  input  wire                          rst,
  cache_refill_controller_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MEM_RD = 2'd1,
    S_MEM_WR = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  hit_q, hit_d;
  logic                  we_q, we_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  // State and request latches; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      we_q       <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      we_q       <= we_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state and output decode. While rst is high every control output is
  // forced low so an in-flight memory request and the stall drop at once.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    we_d       = we_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    bus.stall_o      = 1'b0;
    bus.rdata_o      = '0;
    bus.cache_addr_o = addr_q;
    bus.cache_fill_o = 1'b0;
    bus.mem_req_o    = 1'b0;
    bus.mem_we_o     = 1'b0;

    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          bus.cache_addr_o = bus.addr_i;
          if (bus.req_i) begin
            if (!bus.we_i && bus.cache_hit_i) begin
              bus.rdata_o = bus.cache_rdata_i;
              if (hit_cnt_q != c_cnt_max) hit_cnt_d = hit_cnt_q + c_cnt_one;
            end else if (!bus.we_i) begin
              bus.stall_o = 1'b1;
              addr_d      = bus.addr_i;
              we_d        = 1'b0;
              state_d     = S_MEM_RD;
              if (miss_cnt_q != c_cnt_max) miss_cnt_d = miss_cnt_q + c_cnt_one;
            end else begin
              bus.stall_o = 1'b1;
              addr_d      = bus.addr_i;
              wdata_d     = bus.wdata_i;
              hit_d       = bus.cache_hit_i;
              we_d        = 1'b1;
              state_d     = S_MEM_WR;
            end
          end
        end
        S_MEM_RD: begin
          bus.mem_req_o = 1'b1;
          bus.stall_o   = 1'b1;
          if (bus.mem_ack_i) begin
            rdata_d = bus.mem_rdata_i;
            state_d = S_RESP;
          end
        end
        S_MEM_WR: begin
          bus.mem_req_o = 1'b1;
          bus.mem_we_o  = 1'b1;
          bus.stall_o   = 1'b1;
          if (bus.mem_ack_i) state_d = S_RESP;
        end
        S_RESP: begin
          // Refills always write; stores only update a line already present.
          bus.cache_fill_o = we_q ? hit_q : 1'b1;
          bus.rdata_o      = rdata_q;
          state_d          = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Memory address/data come straight from the latches so they stay stable
  // for the whole request; the fill data picks the store word or the refill.
  always_comb begin
    bus.mem_addr_o    = addr_q;
    bus.mem_wdata_o   = wdata_q;
    bus.cache_wdata_o = we_q ? wdata_q : rdata_q;
    bus.hit_count_o   = hit_cnt_q;
    bus.miss_count_o  = miss_cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_controller.sv
//==============================================================================
// Module      : tb_cache_refill_controller
// Description : Directed self-checking bench for cache_refill_controller with
//               scoreboards for expected load data and memory transactions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cache_refill_controller;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] rd_q[$];
  mem_exp_t      mem_q[$];

  cache_refill_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  cache_refill_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Pop the scoreboard whenever the CPU sees load data this cycle.
  task automatic sample_load(input string tag);
    logic [DW-1:0] e;
    if (bus.req_i && !bus.we_i && !bus.stall_o) begin
      chk({tag, "_rd_sb_nonempty"}, 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        e = rd_q.pop_front();
        chk({tag, "_rdata"}, bus.rdata_o, e);
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.req_i     = 1'b0;
    bus.we_i      = 1'b0;
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
  endtask

  // One CPU access, served by a bench memory that acks on the lat-th request
  // cycle. Returns at the negedge of the completing cycle, request still held.
  task automatic do_access(input string tag, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic hit,
                           input logic [DW-1:0] crd, input int lat,
                           input logic [DW-1:0] mrd, input logic exp_fill);
    int   stall_cnt = 0;
    int   req_cnt   = 0;
    logic done      = 1'b0;
    logic is_hit_ld = !we && hit;
    for (int cyc = 0; cyc < 32 && !done; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        bus.req_i         = 1'b1;
        bus.we_i          = we;
        bus.addr_i        = addr;
        bus.wdata_i       = wdata;
        bus.cache_hit_i   = hit;
        bus.cache_rdata_i = crd;
        bus.mem_rdata_i   = mrd;
        if (!we) rd_q.push_back(is_hit_ld ? crd : mrd);
        if (!is_hit_ld) mem_q.push_back('{we, addr, wdata});
      end
      if (bus.mem_req_o) req_cnt++;
      bus.mem_ack_i = bus.mem_req_o && (req_cnt == lat);
      @(negedge clk);
      if (bus.mem_req_o) begin
        chk({tag, "_mem_q_nonempty"}, 32'(mem_q.size() != 0), 32'd1);
        if (mem_q.size() != 0) begin
          chk({tag, "_mem_addr"}, bus.mem_addr_o, mem_q[0].addr);
          chk({tag, "_mem_we"}, 32'(bus.mem_we_o), 32'(mem_q[0].we));
          if (mem_q[0].we) chk({tag, "_mem_wdata"}, bus.mem_wdata_o, mem_q[0].data);
          if (bus.mem_ack_i) void'(mem_q.pop_front());
        end
      end
      if (bus.stall_o) begin
        stall_cnt++;
      end else begin
        done = 1'b1;
        sample_load(tag);
        chk({tag, "_fill"}, 32'(bus.cache_fill_o), 32'(exp_fill));
        if (is_hit_ld) begin
          chk({tag, "_cache_addr"}, bus.cache_addr_o, addr);
        end else begin
          chk({tag, "_resp_cache_addr"}, bus.cache_addr_o, addr);
          chk({tag, "_cache_wdata"}, bus.cache_wdata_o, we ? wdata : mrd);
        end
      end
    end
    chk({tag, "_completed"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), is_hit_ld ? 32'd0 : 32'(lat + 1));
    chk({tag, "_mem_req_cycles"}, 32'(req_cnt), is_hit_ld ? 32'd0 : 32'(lat));
    bus.mem_ack_i = 1'b0;
  endtask

  initial begin
    bus.req_i         = 1'b0;
    bus.we_i          = 1'b0;
    bus.addr_i        = '0;
    bus.wdata_i       = '0;
    bus.cache_rdata_i = '0;
    bus.cache_hit_i   = 1'b0;
    bus.mem_rdata_i   = '0;
    bus.mem_ack_i     = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_fill", 32'(bus.cache_fill_o), 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_cache_wdata", bus.cache_wdata_o, 32'd0);
    chk("rst_hit_cnt", 32'(bus.hit_count_o), 32'd0);
    chk("rst_miss_cnt", 32'(bus.miss_count_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    // Load hit, then load miss with 3-cycle memory, then back-to-back hit
    do_access("ld_hit", 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 1, 32'h0, 1'b0);
    do_access("ld_miss", 1'b0, 32'h200, 32'h0, 1'b0, 32'h0, 3, 32'h12345678, 1'b1);
    chk("ld_miss_hit_cnt", 32'(bus.hit_count_o), 32'd1);
    chk("ld_miss_miss_cnt", 32'(bus.miss_count_o), 32'd1);
    do_access("b2b_hit", 1'b0, 32'h104, 32'h0, 1'b1, 32'hCAFEF00D, 1, 32'h0, 1'b0);
    idle_cycle();
    chk("b2b_hit_cnt", 32'(bus.hit_count_o), 32'd2);

    // Stores: miss does not allocate, hit updates the line
    do_access("st_miss", 1'b1, 32'h300, 32'hA5A5A5A5, 1'b0, 32'h0, 1, 32'h0, 1'b0);
    do_access("st_hit", 1'b1, 32'h300, 32'hA5A5A5A5, 1'b1, 32'h0, 2, 32'h0, 1'b1);
    idle_cycle();
    chk("st_hit_cnt", 32'(bus.hit_count_o), 32'd2);
    chk("st_miss_cnt", 32'(bus.miss_count_o), 32'd1);
    chk("st_fill_idle", 32'(bus.cache_fill_o), 32'd0);

    // Reset asserted in the second MEM_RD cycle, then a spurious ack
    @(posedge clk); #1;
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h400; bus.cache_hit_i = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_rd1_req", 32'(bus.mem_req_o), 32'd1);
    @(posedge clk); #1;
    chk("rstmid_rd2_req", 32'(bus.mem_req_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("rstmid_stall", 32'(bus.stall_o), 32'd0);
    chk("rstmid_fill", 32'(bus.cache_fill_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_i = 1'b0;
    bus.mem_ack_i = 1'b1;
    bus.mem_rdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    chk("spur_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("spur_stall", 32'(bus.stall_o), 32'd0);
    chk("spur_fill", 32'(bus.cache_fill_o), 32'd0);
    idle_cycle();
    chk("spur_fill_next", 32'(bus.cache_fill_o), 32'd0);
    chk("spur_rdata", bus.rdata_o, 32'd0);
    chk("spur_hit_cnt", 32'(bus.hit_count_o), 32'd0);
    chk("spur_miss_cnt", 32'(bus.miss_count_o), 32'd0);

    // 17 consecutive hits saturate the 4-bit hit counter at 0xF
    for (int i = 1; i <= 17; i++) begin
      do_access($sformatf("sat%0d", i), 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 1'b1,
                32'h5A000000 + 32'(i), 1, 32'h0, 1'b0);
      chk($sformatf("sat%0d_hit_cnt", i), 32'(bus.hit_count_o), (i - 1) > 15 ? 32'd15 : 32'(i - 1));
    end
    idle_cycle();
    chk("sat_hit_cnt_final", 32'(bus.hit_count_o), 32'd15);
    chk("sat_miss_cnt_final", 32'(bus.miss_count_o), 32'd0);

    chk("rd_sb_drained", 32'(rd_q.size()), 32'd0);
    chk("mem_sb_drained", 32'(mem_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time bound so a stuck DUT still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/cache_refill_controller.md
# cache_refill_controller

Sequencing controller between the CPU data-memory port, the two-way set-associative data cache, and main data memory. Serves read hits from the cache with zero stall, stalls the pipeline on read misses while fetching the word from memory and refilling the cache, and implements write-through, no-write-allocate stores. Keeps saturating hit/miss counters for performance measurement.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, byte address width
- `CNT_WIDTH`, 32, width of each performance counter

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_i`  in  1  CPU access valid this cycle
- `we_i`  in  1  1 = store, 0 = load; qualified by `req_i`
- `addr_i`  in  ADDR_WIDTH  CPU byte address
- `wdata_i`  in  DATA_WIDTH  store data
- `rdata_o`  out  DATA_WIDTH  load data; valid when `req_i & !we_i & !stall_o`
- `stall_o`  out  1  CPU must hold request and freeze pipeline
- `cache_addr_o`  out  ADDR_WIDTH  address to cache (lookup and fill)
- `cache_wdata_o`  out  DATA_WIDTH  fill/update data to cache
- `cache_fill_o`  out  1  cache write strobe, held high a full cycle
- `cache_rdata_i`  in  DATA_WIDTH  cache read data
- `cache_hit_i`  in  1  cache hit for `cache_addr_o`
- `mem_req_o`  out  1  memory request, held until ack
- `mem_we_o`  out  1  memory write
- `mem_addr_o`  out  ADDR_WIDTH  memory address
- `mem_wdata_o`  out  DATA_WIDTH  memory write data
- `mem_rdata_i`  in  DATA_WIDTH  memory read data, valid with ack
- `mem_ack_i`  in  1  memory completion, sampled only while `mem_req_o`=1
- `hit_count_o`  out  CNT_WIDTH  load hits
- `miss_count_o`  out  CNT_WIDTH  load misses

## Operation
- FSM states: IDLE, MEM_RD, MEM_WR, RESP.
- IDLE: `cache_addr_o = addr_i`. If `req_i & !we_i & cache_hit_i`: `rdata_o = cache_rdata_i`, `stall_o`=0, hit_count++ and stay IDLE. If `req_i & !we_i & !cache_hit_i`: `stall_o`=1, latch addr, miss_count++, go MEM_RD. If `req_i & we_i`: `stall_o`=1, latch addr, wdata and `cache_hit_i`, go MEM_WR. No `req_i`: stay IDLE, `stall_o`=0.
- MEM_RD: `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o` = latched addr, `stall_o`=1. On `mem_ack_i`: latch `mem_rdata_i`, go RESP.
- MEM_WR: `mem_req_o`=1, `mem_we_o`=1, address/data from latches, `stall_o`=1. On `mem_ack_i` go RESP.
- RESP: `stall_o`=0, `cache_addr_o` = latched addr, `cache_wdata_o` = latched data. `cache_fill_o`=1 for a read refill; for a store, `cache_fill_o` = latched hit (update only; a store miss never allocates). `rdata_o` = latched memory data. Always returns to IDLE next cycle.
- `cache_fill_o` is high for the entire RESP cycle so a cache writing on the falling edge captures it.
- Counters saturate at all-ones; they do not wrap. Stores are not counted.
- Outside MEM_RD/MEM_WR, `mem_req_o`=0 and `mem_ack_i` is ignored.

## Timing
- Reset (async, immediate): state IDLE; `stall_o`, `mem_req_o`, `mem_we_o`, `cache_fill_o` = 0; `rdata_o`, `mem_addr_o`, `mem_wdata_o`, `cache_wdata_o`, latches and counters = 0. Reset during MEM_RD/MEM_WR drops `mem_req_o` combinationally; no fill occurs.
- Load hit latency: 0 cycles (combinational through the cache).
- Load miss: request cycle N (stall), `mem_req_o` high from N+1; ack at cycle N+k moves to RESP at N+k+1; total N+k+2 cycles to completion. Ack in the first MEM_RD cycle (k=1) is legal: minimum miss penalty is 2 stall cycles.
- Store: identical timing to load miss.
- `mem_addr_o`, `mem_we_o`, `mem_wdata_o` stable for every cycle `mem_req_o` is high.
- A request presented in IDLE in the cycle after RESP is serviced normally (no bubble required).

## Test plan
- Reset then load to 0x100 with `cache_hit_i`=1, `cache_rdata_i`=0xDEADBEEF -> `rdata_o`=0xDEADBEEF, `stall_o`=0 same cycle, hit_count=1.
- Load miss 0x200, memory acks after 3 cycles with 0x12345678 -> `stall_o` high 4 cycles, `mem_req_o` held 3 cycles at addr 0x200, RESP: `cache_fill_o`=1, `cache_wdata_o`=`rdata_o`=0x12345678, miss_count=1.
- Store miss 0x300 data 0xA5A5A5A5, ack after 1 cycle -> `mem_we_o`=1 with correct addr/data, RESP with `cache_fill_o`=0; same as store hit -> `cache_fill_o`=1, `cache_wdata_o`=0xA5A5A5A5.
- Assert `rst` in second MEM_RD cycle -> `mem_req_o` and `stall_o` fall immediately; spurious `mem_ack_i` next cycle ignored; counters 0.
- Preload hit_count to max via `CNT_WIDTH`=4 and 17 load hits -> hit_count stays 0xF.
- Back-to-back: miss completing in RESP, then hit in next cycle -> hit served with zero stall, `cache_fill_o` low.
